// File: rtl/four_bit_alu_pkg.sv
// Shared widths, Sel encodings and the registered result bundle for four_bit_alu.
package four_bit_alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned SUM_W  = DATA_W + 1;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_CMP = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [SUM_W-1:0]  y_add_sub;
    logic [DATA_W-1:0] y_and;
    logic              eq;
    logic              gt;
    logic              lt;
  } alu_result_t;

endpackage

// File: rtl/alu_rca4.sv
// 4-bit ripple-carry adder built from a chain of full-adder stages.
module alu_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/four_bit_alu.sv
// Registered 4-bit ALU: add, subtract, AND and unsigned compare, one-cycle latency.
module four_bit_alu
  import four_bit_alu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       A,
  input  logic [DATA_W-1:0]       B,
  input  logic [SEL_W-1:0]        Sel,
  output logic [SUM_W-1:0]        Y_addSub,
  output logic [DATA_W-1:0]       Y_and,
  output logic                    Eq,
  output logic                    Gt,
  output logic                    Lt
);

  alu_op_e           op;
  logic [DATA_W-1:0] b_op;
  logic              cin;
  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              borrow;
  logic              eq_c;
  alu_result_t       res_d;
  alu_result_t       res_q;

  assign op = alu_op_e'(Sel);

  // Subtract and compare share the A + ~B + 1 path; only add feeds B straight through.
  assign cin  = (op != OP_ADD);
  assign b_op = cin ? ~B : B;

  alu_rca4 u_rca4 (
    .a    (A),
    .b    (b_op),
    .cin  (cin),
    .s    (sum),
    .cout (cout)
  );

  assign borrow = ~cout;
  assign eq_c   = ((A ^ B) == DATA_W'(0));

  always_comb begin
    res_d = '0;
    case (op)
      OP_ADD: res_d.y_add_sub = {cout, sum};
      OP_SUB: res_d.y_add_sub = {borrow, sum};
      OP_AND: res_d.y_and     = A & B;
      OP_CMP: begin
        res_d.eq = eq_c;
        res_d.lt = borrow;
        res_d.gt = ~eq_c & ~borrow;
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign Y_addSub = res_q.y_add_sub;
  assign Y_and    = res_q.y_and;
  assign Eq       = res_q.eq;
  assign Gt       = res_q.gt;
  assign Lt       = res_q.lt;

endmodule

// File: tb/tb_four_bit_alu.sv
// Directed self-checking bench for four_bit_alu: reset, each op, wrap, latency, async reset.
module tb_four_bit_alu;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] Sel;
  logic [4:0] Y_addSub;
  logic [3:0] Y_and;
  logic       Eq;
  logic       Gt;
  logic       Lt;

  int unsigned n_compared;
  int unsigned n_mismatched;
  logic [11:0] exp_q;

  four_bit_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Sel      (Sel),
    .Y_addSub (Y_addSub),
    .Y_and    (Y_and),
    .Eq       (Eq),
    .Gt       (Gt),
    .Lt       (Lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input logic [4:0] ya, input logic [3:0] yn,
                                     input logic e, input logic g, input logic l);
    return {ya, yn, e, g, l};
  endfunction

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {Y_addSub, Y_and, Eq, Gt, Lt};
    n_compared++;
    assert (obs === exp)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed Y_addSub=%b Y_and=%b Eq/Gt/Lt=%b, expected Y_addSub=%b Y_and=%b Eq/Gt/Lt=%b",
             tag, obs[11:7], obs[6:3], obs[2:0], exp[11:7], exp[6:3], exp[2:0]);
    end
  endtask

  // Drive one op, confirm the previous result holds until the edge, then the new one follows it.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] sel, input logic [11:0] exp);
    A = a; B = b; Sel = sel;
    #2;
    check({tag, "_hold"}, exp_q);
    @(posedge clk);
    #1;
    check(tag, exp);
    exp_q = exp;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    exp_q        = '0;
    rst_n = 1'b0;
    A = 4'h0; B = 4'h0; Sel = 2'b00;

    // Reset held with random stimulus across several edges.
    repeat (4) begin
      A   = 4'($urandom);
      B   = 4'($urandom);
      Sel = 2'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", 12'h000);
    end

    @(negedge clk);
    rst_n = 1'b1;

    step("add_ff",      4'b1111, 4'b1111, 2'b00, mk(5'b11110, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("sub_ff",      4'b1111, 4'b1111, 2'b01, mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("and_ff",      4'b1111, 4'b1111, 2'b10, mk(5'b00000, 4'b1111, 1'b0, 1'b0, 1'b0));
    step("and_a6",      4'b1010, 4'b0110, 2'b10, mk(5'b00000, 4'b0010, 1'b0, 1'b0, 1'b0));
    step("cmp_eq",      4'b1111, 4'b1111, 2'b11, mk(5'b00000, 4'b0000, 1'b1, 1'b0, 1'b0));
    step("cmp_lt",      4'b0011, 4'b0101, 2'b11, mk(5'b00000, 4'b0000, 1'b0, 1'b0, 1'b1));
    step("cmp_gt",      4'b1000, 4'b0111, 2'b11, mk(5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0));
    step("sub_wrap35",  4'b0011, 4'b0101, 2'b01, mk(5'b11110, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("sub_wrap0f",  4'b0000, 4'b1111, 2'b01, mk(5'b10001, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("add_carry",   4'b1001, 4'b1000, 2'b00, mk(5'b10001, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("add_small",   4'b0011, 4'b0100, 2'b00, mk(5'b00111, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("sub_pos",     4'b1100, 4'b0101, 2'b01, mk(5'b00111, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("cmp_eq0",     4'b0000, 4'b0000, 2'b11, mk(5'b00000, 4'b0000, 1'b1, 1'b0, 1'b0));

    // Same operands, Sel changes every cycle.
    step("sel_add",     4'b0101, 4'b0011, 2'b00, mk(5'b01000, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("sel_sub",     4'b0101, 4'b0011, 2'b01, mk(5'b00010, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("sel_and",     4'b0101, 4'b0011, 2'b10, mk(5'b00000, 4'b0001, 1'b0, 1'b0, 1'b0));
    step("sel_cmp",     4'b0101, 4'b0011, 2'b11, mk(5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0));
    step("sel_add2",    4'b0101, 4'b0011, 2'b00, mk(5'b01000, 4'b0000, 1'b0, 1'b0, 1'b0));

    // Async reset between edges clears outputs without a clock edge.
    A = 4'b1111; B = 4'b0001; Sel = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 12'h000);
    @(posedge clk);
    #1;
    check("async_rst_edge", 12'h000);

    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '0;
    step("post_rst_add", 4'b0010, 4'b0010, 2'b00, mk(5'b00100, 4'b0000, 1'b0, 1'b0, 1'b0));
    step("post_rst_and", 4'b1100, 4'b1010, 2'b10, mk(5'b00000, 4'b1000, 1'b0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
